// File: rtl/uart_sv_if.sv
// Host-side and pin-side signal bundle for uart_sv.
// master: host (drives writes/reads and the Rx pin); slave: the UART itself.
interface uart_sv_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_write;
   logic                 tx_full;
   logic                 tx_empty;
   logic                 tx_busy;
   logic                 tx;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_parity_err;
   logic                 rx_frame_err;
   logic                 rx_read;
   logic                 rx_empty;
   logic                 rx_full;
   logic                 rx_overrun;

   modport master (
      output tx_data, tx_write, rx_read, rx,
      input  tx_full, tx_empty, tx_busy, tx, rx_data, rx_parity_err,
             rx_frame_err, rx_empty, rx_full, rx_overrun
   );

   modport slave (
      input  tx_data, tx_write, rx_read, rx,
      output tx_full, tx_empty, tx_busy, tx, rx_data, rx_parity_err,
             rx_frame_err, rx_empty, rx_full, rx_overrun
   );
endinterface

// File: rtl/uart_sv.sv
// Full-duplex UART with TX/RX FIFOs. Frame: start, DATA_BITS data (LSB first),
// even parity, STOP_BITS stop bits. Bit period = SYSCLK_RATE/BAUD_RATE clocks.
// Optional: define UART_LOOPBACK_EN to feed the receiver from the internal Tx.
//
// state    | meaning (shared by TX and RX machines)
// S_IDLE   | line idle, waiting for FIFO data (TX) or a start edge (RX)
// S_START  | start bit (RX: waiting for the mid-bit confirm sample)
// S_DATA   | data bits, LSB first
// S_PARITY | even parity bit
// S_STOP   | stop bit(s)

module uart_sv_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         full
);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            do_push, do_pop;

   // a pop on empty is ignored; a push on full only lands if a pop frees a slot
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign empty   = (count == '0);
   assign full    = (count == CNTW'(DEPTH));
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // storage array, written at the tail
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // wrap-around pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end
endmodule

module uart_sv #(
   parameter int SYSCLK_RATE = 4,
   parameter int BAUD_RATE   = 1,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 2,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic   clk,
   input  logic   rst_n,
   uart_sv_if.slave u
);
   localparam int BIT_CLKS = SYSCLK_RATE / BAUD_RATE;
   localparam int CW       = $clog2(BIT_CLKS) + 1;
   localparam int DW       = $clog2(DATA_BITS) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
   localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   if (BIT_CLKS < 4) begin : g_bad_baud
      $error("uart_sv: SYSCLK_RATE/BAUD_RATE must be at least 4");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- transmit ----------------
   state_t               tx_state;
   logic [CW-1:0]        tx_cnt;
   logic [DW-1:0]        tx_bit_idx;
   logic                 tx_stop_idx;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par;
   logic                 tx_q;
   logic                 tx_busy_q;
   logic [DATA_BITS-1:0] tx_head;
   logic                 tx_fifo_empty, tx_fifo_full;
   logic                 tx_pop;

   // a new frame is loaded from idle or straight out of the last stop bit
   assign tx_pop = !tx_fifo_empty &&
                   (tx_state == S_IDLE ||
                    (tx_state == S_STOP && tx_cnt == '0 && tx_stop_idx == STOP_LAST));

   uart_sv_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(u.tx_write), .wdata(u.tx_data),
      .pop(tx_pop), .rdata(tx_head), .empty(tx_fifo_empty), .full(tx_fifo_full)
   );

   // serializer: each bit is held BIT_CLKS cycles via a down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state    <= S_IDLE;
         tx_cnt      <= '0;
         tx_bit_idx  <= '0;
         tx_stop_idx <= 1'b0;
         tx_sh       <= '0;
         tx_par      <= 1'b0;
         tx_q        <= 1'b1;
         tx_busy_q   <= 1'b0;
      end else if (tx_state == S_IDLE) begin
         if (tx_pop) begin
            tx_sh     <= tx_head;
            tx_par    <= ^tx_head;
            tx_cnt    <= BIT_LAST;
            tx_q      <= 1'b0;
            tx_busy_q <= 1'b1;
            tx_state  <= S_START;
         end
      end else if (tx_cnt != '0) begin
         tx_cnt <= tx_cnt - 1'b1;
      end else begin
         tx_cnt <= BIT_LAST;
         case (tx_state)
            S_START: begin
               tx_q       <= tx_sh[0];
               tx_sh      <= tx_sh >> 1;
               tx_bit_idx <= '0;
               tx_state   <= S_DATA;
            end
            S_DATA: begin
               if (tx_bit_idx == DATA_LAST) begin
                  tx_q     <= tx_par;
                  tx_state <= S_PARITY;
               end else begin
                  tx_bit_idx <= tx_bit_idx + 1'b1;
                  tx_q       <= tx_sh[0];
                  tx_sh      <= tx_sh >> 1;
               end
            end
            S_PARITY: begin
               tx_q        <= 1'b1;
               tx_stop_idx <= 1'b0;
               tx_state    <= S_STOP;
            end
            S_STOP: begin
               if (tx_stop_idx != STOP_LAST) begin
                  tx_stop_idx <= tx_stop_idx + 1'b1;
               end else if (tx_pop) begin
                  tx_sh    <= tx_head;
                  tx_par   <= ^tx_head;
                  tx_q     <= 1'b0;
                  tx_state <= S_START;
               end else begin
                  tx_q      <= 1'b1;
                  tx_busy_q <= 1'b0;
                  tx_state  <= S_IDLE;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   assign u.tx       = tx_q;
   assign u.tx_busy  = tx_busy_q;
   assign u.tx_empty = tx_fifo_empty;
   assign u.tx_full  = tx_fifo_full;

   // ---------------- receive ----------------
   logic                 rx_in, rx_meta, rx_s;
   state_t               rx_state;
   logic [CW-1:0]        rx_cnt;
   logic [DW-1:0]        rx_bit_idx;
   logic                 rx_stop_idx;
   logic [DATA_BITS-1:0] rx_sh;
   logic [DATA_BITS:0]   rx_shift_in;
   logic                 rx_perr;
   logic                 rx_armed;
   logic                 rx_push;
   logic [DATA_BITS+1:0] rx_wdata, rx_head;
   logic                 rx_fifo_empty, rx_fifo_full;
   logic                 rx_ovr;

`ifdef UART_LOOPBACK_EN
   assign rx_in = tx_q;
`else
   assign rx_in = u.rx;
`endif

   // two-flop synchronizer for the asynchronous serial input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   assign rx_shift_in = {rx_s, rx_sh} >> 1;
   // a low stop bit ends the frame on the spot, so it is pushed with ferr set
   assign rx_push  = (rx_state == S_STOP) && (rx_cnt == '0) &&
                     (!rx_s || rx_stop_idx == STOP_LAST);
   assign rx_wdata = {rx_sh, rx_perr, !rx_s};

   // deserializer: mid-bit sampling; rx_armed blocks restart until the line is seen high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state    <= S_IDLE;
         rx_cnt      <= '0;
         rx_bit_idx  <= '0;
         rx_stop_idx <= 1'b0;
         rx_sh       <= '0;
         rx_perr     <= 1'b0;
         rx_armed    <= 1'b1;
      end else if (rx_state == S_IDLE) begin
         if (rx_s) begin
            rx_armed <= 1'b1;
         end else if (rx_armed) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= S_START;
         end
      end else if (rx_cnt != '0) begin
         rx_cnt <= rx_cnt - 1'b1;
      end else begin
         rx_cnt <= BIT_LAST;
         case (rx_state)
            S_START: begin
               if (rx_s) begin
                  rx_state <= S_IDLE;
               end else begin
                  rx_bit_idx <= '0;
                  rx_state   <= S_DATA;
               end
            end
            S_DATA: begin
               rx_sh <= rx_shift_in[DATA_BITS-1:0];
               if (rx_bit_idx == DATA_LAST) rx_state <= S_PARITY;
               else                         rx_bit_idx <= rx_bit_idx + 1'b1;
            end
            S_PARITY: begin
               rx_perr     <= rx_s ^ (^rx_sh);
               rx_stop_idx <= 1'b0;
               rx_state    <= S_STOP;
            end
            S_STOP: begin
               if (!rx_s) begin
                  rx_armed <= 1'b0;
                  rx_state <= S_IDLE;
               end else if (rx_stop_idx == STOP_LAST) begin
                  rx_state <= S_IDLE;
               end else begin
                  rx_stop_idx <= rx_stop_idx + 1'b1;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   uart_sv_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_wdata),
      .pop(u.rx_read), .rdata(rx_head), .empty(rx_fifo_empty), .full(rx_fifo_full)
   );

   // sticky overrun: set when a completed frame finds no room, cleared by a read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               rx_ovr <= 1'b0;
      else if (u.rx_read)                       rx_ovr <= 1'b0;
      else if (rx_push && rx_fifo_full)         rx_ovr <= 1'b1;
   end

   assign u.rx_data       = rx_head[DATA_BITS+1:2];
   assign u.rx_parity_err = rx_head[1];
   assign u.rx_frame_err  = rx_head[0];
   assign u.rx_empty      = rx_fifo_empty;
   assign u.rx_full       = rx_fifo_full;
   assign u.rx_overrun    = rx_ovr;
endmodule

// File: tb/tb_uart_sv.sv
// Directed bench for uart_sv at default parameters (4 clocks per bit).
module tb_uart_sv;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   uart_sv_if #(.DATA_BITS(8)) u_if ();

   uart_sv #(
      .SYSCLK_RATE(4), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .u(u_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // expected line level for bit j (0=start, 1..8 data, 9 parity, 10..11 stop)
   function automatic logic exp_bit(input logic [7:0] d, input int j);
      if (j == 0)      return 1'b0;
      else if (j <= 8) return d[j-1];
      else if (j == 9) return ^d;
      else             return 1'b1;
   endfunction

   // stream of back-to-back frames carrying words 0,1,2,...
   function automatic logic exp_stream(input int s);
      return exp_bit(8'(s / 48), (s % 48) / 4);
   endfunction

   task automatic send_rx(input logic [7:0] d, input logic par, input logic stop1);
      logic [11:0] bits;
      bits = {1'b1, stop1, par, d, 1'b0};
      for (int b = 0; b < 12; b++) begin
         u_if.rx = bits[b];
         repeat (4) @(negedge clk);
      end
      u_if.rx = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic do_read();
      u_if.rx_read = 1'b1;
      @(negedge clk);
      u_if.rx_read = 1'b0;
   endtask

   initial begin
      u_if.tx_data  = '0;
      u_if.tx_write = 1'b0;
      u_if.rx_read  = 1'b0;
      u_if.rx       = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_tx", u_if.tx, 1);
      check("rst_tx_busy", u_if.tx_busy, 0);
      check("rst_tx_empty", u_if.tx_empty, 1);
      check("rst_tx_full", u_if.tx_full, 0);
      check("rst_rx_empty", u_if.rx_empty, 1);
      check("rst_rx_full", u_if.rx_full, 0);
      check("rst_rx_data", u_if.rx_data, 0);
      check("rst_rx_perr", u_if.rx_parity_err, 0);
      check("rst_rx_ferr", u_if.rx_frame_err, 0);
      check("rst_rx_ovr", u_if.rx_overrun, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single frame 0xA5: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1,1
      u_if.tx_data  = 8'hA5;
      u_if.tx_write = 1'b1;
      @(negedge clk);
      u_if.tx_write = 1'b0;
      check("a5_queued_not_empty", u_if.tx_empty, 0);
      check("a5_tx_still_idle", u_if.tx, 1);
      for (int s = 0; s < 48; s++) begin
         @(negedge clk);
         if (s == 0) check("a5_busy", u_if.tx_busy, 1);
         check("a5_tx_bit", u_if.tx, exp_bit(8'hA5, s / 4));
      end
      @(negedge clk);
      check("a5_done_busy", u_if.tx_busy, 0);
      check("a5_done_empty", u_if.tx_empty, 1);
      check("a5_done_tx", u_if.tx, 1);

      // nine words back-to-back; word 0 leaves at once, so all nine fit
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i >= 2) check("b2b_tx", u_if.tx, exp_stream(i - 2));
         u_if.tx_data  = 8'(i);
         u_if.tx_write = 1'b1;
      end
      @(negedge clk);
      u_if.tx_write = 1'b0;
      check("b2b_tx_full", u_if.tx_full, 1);
      check("b2b_tx", u_if.tx, exp_stream(7));
      for (int s = 8; s < 432; s++) begin
         @(negedge clk);
         check("b2b_tx", u_if.tx, exp_stream(s));
      end
      @(negedge clk);
      check("b2b_done_busy", u_if.tx_busy, 0);
      check("b2b_done_empty", u_if.tx_empty, 1);

      // good frame 0x3C (four ones -> parity 0)
      send_rx(8'h3C, 1'b0, 1'b1);
      check("rx3c_empty", u_if.rx_empty, 0);
      check("rx3c_data", u_if.rx_data, 8'h3C);
      check("rx3c_perr", u_if.rx_parity_err, 0);
      check("rx3c_ferr", u_if.rx_frame_err, 0);
      do_read();
      check("rx3c_read_empty", u_if.rx_empty, 1);

      // 0x01 needs parity 1; send 0
      send_rx(8'h01, 1'b0, 1'b1);
      check("perr_data", u_if.rx_data, 8'h01);
      check("perr_flag", u_if.rx_parity_err, 1);
      check("perr_ferr", u_if.rx_frame_err, 0);
      do_read();

      // 0x55 good parity, first stop bit low
      send_rx(8'h55, 1'b0, 1'b0);
      check("ferr_data", u_if.rx_data, 8'h55);
      check("ferr_perr", u_if.rx_parity_err, 0);
      check("ferr_flag", u_if.rx_frame_err, 1);
      do_read();
      check("ferr_read_empty", u_if.rx_empty, 1);

      // nine frames with no reads: eighth fills, ninth is dropped
      for (int i = 0; i < 9; i++) begin
         send_rx(8'(i), ^(8'(i)), 1'b1);
         if (i == 7) begin
            check("ovr_full_at8", u_if.rx_full, 1);
            check("ovr_not_yet", u_if.rx_overrun, 0);
         end
      end
      check("ovr_set", u_if.rx_overrun, 1);
      check("ovr_still_full", u_if.rx_full, 1);
      check("ovr_head", u_if.rx_data, 8'h00);
      do_read();
      check("ovr_cleared", u_if.rx_overrun, 0);
      check("ovr_not_full", u_if.rx_full, 0);
      for (int i = 1; i < 8; i++) begin
         check("ovr_drain_data", u_if.rx_data, 32'(i));
         do_read();
      end
      check("ovr_drained_empty", u_if.rx_empty, 1);

      // one-clock low glitch while idle
      u_if.rx = 1'b0;
      @(negedge clk);
      u_if.rx = 1'b1;
      repeat (60) @(negedge clk);
      check("glitch_empty", u_if.rx_empty, 1);
      send_rx(8'hC3, 1'b0, 1'b1);
      check("post_glitch_data", u_if.rx_data, 8'hC3);
      do_read();

      // reset mid-frame while sending 0x00 (line low)
      u_if.tx_data  = 8'h00;
      u_if.tx_write = 1'b1;
      @(negedge clk);
      u_if.tx_write = 1'b0;
      repeat (6) @(negedge clk);
      check("midrst_tx_low", u_if.tx, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx_high", u_if.tx, 1);
      check("midrst_busy", u_if.tx_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("postrst_tx", u_if.tx, 1);
      check("postrst_tx_empty", u_if.tx_empty, 1);
      check("postrst_rx_empty", u_if.rx_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_sv.md
Name: uart_sv

Overview:
- Parameterized full-duplex UART with a transmit FIFO and a receive FIFO.
- Frame format: 1 start bit, DATA_BITS data bits LSB first, 1 even-parity bit, STOP_BITS stop bits (TX_BITS = DATA_BITS+STOP_BITS+2).
- Sits between a parallel host interface in the SysClk domain and the serial Tx/Rx pins.

Parameters:
- SYSCLK_RATE, 4, system clock frequency in Hz; legal range 4..99999999.
- BAUD_RATE, 1, serial bit rate in baud; legal range 1..6999999.
- DATA_BITS, 8, data bits per frame; legal range 1..8.
- STOP_BITS, 2, stop bits per frame; legal range 1..2.
- FIFO_DEPTH, 8, entries in each FIFO; legal range 1..16.

Ports:
- SysClk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- TxData  in  DATA_BITS  word to transmit.
- TxWrite  in  1  push TxData into TX FIFO.
- TxFull  out  1  TX FIFO full.
- TxEmpty  out  1  TX FIFO empty.
- TxBusy  out  1  serializer mid-frame.
- Tx  out  1  serial output; idle high.
- Rx  in  1  serial input; asynchronous.
- RxData  out  DATA_BITS  head word of RX FIFO (show-ahead).
- RxParityErr  out  1  parity error flag of head word.
- RxFrameErr  out  1  framing error flag of head word.
- RxRead  in  1  pop RX FIFO head.
- RxEmpty  out  1  RX FIFO empty.
- RxFull  out  1  RX FIFO full.
- RxOverrun  out  1  sticky: a received frame was dropped.

Behaviour:
- Bit period: BIT_CLKS = SYSCLK_RATE/BAUD_RATE (integer division). BIT_CLKS >= 4 is required; a parameter check reports an error otherwise.
- Reset state:
  - Tx=1, TxBusy=0, both FIFOs empty (TxEmpty=1, RxEmpty=1, TxFull=0, RxFull=0).
  - RxData=0, RxParityErr=0, RxFrameErr=0, RxOverrun=0.
  - Both state machines in IDLE.
- FIFOs:
  - Circular buffer with wrap-around pointers and a count 0..FIFO_DEPTH.
  - A push when full is dropped. A pop when empty is ignored.
  - Simultaneous push+pop succeeds for both operations and leaves count unchanged, except when empty, where only the push takes effect.
  - RX FIFO entries are DATA_BITS+2 wide (data, parity error, frame error).
- TX state machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE/START.
  - IDLE: if TX FIFO is non-empty, pop the head and enter START the same edge.
  - With TX FIFO empty, TxWrite at edge N makes Tx drop low after edge N+1.
  - Each bit is held exactly BIT_CLKS cycles.
  - Parity bit = XOR of the data bits (even parity).
  - After the last stop bit: if the FIFO is non-empty, go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
  - TxBusy=1 in every state except IDLE.
- RX state machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - Rx passes through a 2-flop synchronizer, reset value 1.
  - IDLE: a synchronized 0 starts a counter; sample at BIT_CLKS/2. If the sample is 1, treat it as a glitch and return to IDLE.
  - Each following bit is sampled every BIT_CLKS cycles at mid-bit.
  - Parity error: the received parity bit != XOR of the received data bits.
  - Frame error: any stop bit sampled 0.
  - At the last stop-bit sample, push {data, perr, ferr}. If the RX FIFO is full (and no RxRead that cycle), drop the frame and set RxOverrun.
  - RxOverrun clears on RxRead.
  - On a frame error, return to IDLE immediately. A new start is recognized only after Rx is sampled high.
- Reset asserted mid-frame: Tx returns high immediately and any partial frame (TX or RX) is discarded.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- When defined: the receiver input is driven from the internal Tx output instead of the Rx pin, and Rx is ignored. Tx still drives the pin.
- When undefined: the receiver samples the Rx pin; no loopback logic exists.

Test Plan:
- Defaults (BIT_CLKS=4), reset, then TxWrite TxData=0xA5 -> Tx low for 4 clocks, then 1,0,1,0,0,1,0,1, parity 0, two stop 1s; frame 48 clocks; then TxEmpty=1, TxBusy=0.
- Serial frame 0x3C with parity 0 and good stops on Rx -> RxEmpty falls, RxData=0x3C, RxParityErr=0, RxFrameErr=0; RxRead -> RxEmpty=1.
- Rx frame 0x01 with parity bit 0 -> RxParityErr=1; separate frame with first stop bit 0 -> RxFrameErr=1.
- Write 9 words 0x00..0x08 in consecutive cycles with FIFO_DEPTH=8 -> TxFull=1; 0x00 pops immediately so 0x08 is also accepted; frames leave back-to-back with no idle gap.
- Send 9 Rx frames without reading -> RxFull=1, 9th dropped, RxOverrun=1; RxRead clears RxOverrun and returns 0x00 first.
- Rx low pulse of 1 clock while idle -> no frame received, RxEmpty stays 1; Reset_n low mid-TX -> Tx=1 at once.
